// File: rtl/ldl_fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the occupancy-width helper.
package ldl_fifo_pkg;

   localparam int FIFO_STD  = 0;   // read data one cycle after the read strobe
   localparam int FIFO_FWFT = 1;   // head word presented before it is consumed

   // Bits needed to hold an occupancy in the range 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ldl_ptr_wrap.sv
// Modulo-DEPTH address pointer: wraps from DEPTH-1 to 0, clears synchronously.
module ldl_ptr_wrap #(
   parameter int AWIDTH = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [AWIDTH-1:0] ptr
);

   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

   logic [AWIDTH-1:0] ptr_q, ptr_d;

   // Next pointer: clear wins, otherwise step with explicit wrap at DEPTH-1.
   always_comb begin
      ptr_d = ptr_q;
      if (clr)
         ptr_d = '0;
      else if (inc)
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AWIDTH'(1);
   end

   // Pointer register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ldl_sfifo_ctrl_pro.sv
// Synchronous FIFO controller for an external one-cycle-latency RAM.
// Supports standard reads and first-word-fall-through with head prefetch.
module ldl_sfifo_ctrl_pro
   import ldl_fifo_pkg::*;
#(
   parameter int AWIDTH = 8,
   parameter int DEPTH  = 256,
   parameter int FWFT   = FIFO_STD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              we,
   input  logic              re,
   input  logic [AWIDTH:0]   af_th,
   input  logic [AWIDTH:0]   ae_th,
   input  logic              clr_err,
   output logic              empty,
   output logic              full,
   output logic              afull,
   output logic              aempty,
   output logic [AWIDTH:0]   count,
   output logic [AWIDTH-1:0] wa,
   output logic [AWIDTH-1:0] ra,
   output logic              mw,
   output logic              mr,
   output logic              ovf,
   output logic              udf
);

   // Occupancy must be able to reach the full address space.
   localparam int            CW      = cnt_width(1 << AWIDTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   if (DEPTH < 2 || DEPTH > (1 << AWIDTH)) begin : g_bad_depth
      $fatal(1, "ldl_sfifo_ctrl_pro: DEPTH must be within 2..2**AWIDTH");
   end
   if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
      $fatal(1, "ldl_sfifo_ctrl_pro: FWFT must be FIFO_STD or FIFO_FWFT");
   end

   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     mem_cnt_q, mem_cnt_d;   // FWFT: words in RAM not yet fetched
   logic              out_valid_q, out_valid_d; // FWFT: RAM output holds the head
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              fw, fr, mr_int, rd_inc;
   logic [AWIDTH-1:0] wr_ptr, rd_ptr;

   assign full  = (count_q == DEPTH_C);
   assign empty = (FWFT == FIFO_FWFT) ? ~out_valid_q : (count_q == '0);

   // Accept/issue decisions and next-state for occupancy, prefetch and errors.
   always_comb begin
      // Nothing reaches the RAM while reset is asserted.
      fw          = rst_n & we & ~full & ~flush;
      fr          = rst_n & re & ~empty & ~flush;
      mr_int      = fr;
      rd_inc      = fr;
      mem_cnt_d   = '0;
      out_valid_d = 1'b0;
      if (FWFT == FIFO_FWFT) begin
         // Fetch when the output slot is free or being drained this cycle.
         mr_int      = rst_n & (mem_cnt_q != '0) & (~out_valid_q | fr) & ~flush;
         rd_inc      = mr_int;
         mem_cnt_d   = mem_cnt_q;
         if (fw & ~mr_int)      mem_cnt_d = mem_cnt_q + CW'(1);
         else if (mr_int & ~fw) mem_cnt_d = mem_cnt_q - CW'(1);
         out_valid_d = mr_int | (out_valid_q & ~fr);
         if (flush) begin
            mem_cnt_d   = '0;
            out_valid_d = 1'b0;
         end
      end

      count_d = count_q;
      if (flush)         count_d = '0;
      else if (fw & ~fr) count_d = count_q + CW'(1);
      else if (fr & ~fw) count_d = count_q - CW'(1);

      // A same-cycle event beats the clear so no error is lost.
      ovf_d = (we & full)  | (ovf_q & ~clr_err);
      udf_d = (re & empty) | (udf_q & ~clr_err);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         count_q     <= count_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

   ldl_ptr_wrap #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_wr_ptr (
      .clk(clk), .rst_n(rst_n), .clr(flush), .inc(fw), .ptr(wr_ptr)
   );

   ldl_ptr_wrap #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_rd_ptr (
      .clk(clk), .rst_n(rst_n), .clr(flush), .inc(rd_inc), .ptr(rd_ptr)
   );

   assign mw     = fw;
   assign mr     = mr_int;
   assign wa     = wr_ptr;
   assign ra     = rd_ptr;
   assign count  = count_q;
   assign afull  = (count_q >= af_th);
   assign aempty = (count_q <= ae_th);
   assign ovf    = ovf_q;
   assign udf    = udf_q;

endmodule

// File: tb/tb_ldl_sfifo_ctrl_pro.sv
// Bench for ldl_sfifo_ctrl_pro: a standard-read and an FWFT instance side by
// side, each with its own RAM model and a count-based reference model.
module tb_ldl_sfifo_ctrl_pro;

   localparam int AW = 3;
   localparam int DP = 5;
   localparam int CW = AW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    we, re, flush, clr_err;
   logic [CW-1:0] af_th, ae_th;
   logic [1:0]    empty, full, afull, aempty, mw, mr, ovf, udf;
   logic [CW-1:0] count [2];
   logic [AW-1:0] wa [2];
   logic [AW-1:0] ra [2];
   logic [7:0]    wdata [2];
   logic [7:0]    rdata [2];
   logic [7:0]    mem [2][8];

   int tests_run = 0;
   int failed    = 0;
   int now       = 0;

   // Reference model: totals of words written, fetched (FWFT) and consumed
   // since the last flush/reset; the FIFO contents are dbuf[rd_n..wr_n-1].
   int         wr_n [2];
   int         rd_n [2];
   int         fe_n [2];
   logic [7:0] dbuf [2][4096];
   logic       m_ovf [2];
   logic       m_udf [2];
   logic       pend_v [2];
   logic [7:0] pend_d [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ldl_sfifo_ctrl_pro #(.AWIDTH(AW), .DEPTH(DP), .FWFT(g)) u_dut (
         .clk(clk), .rst_n(rst_n), .flush(flush[g]), .we(we[g]), .re(re[g]),
         .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err[g]),
         .empty(empty[g]), .full(full[g]), .afull(afull[g]), .aempty(aempty[g]),
         .count(count[g]), .wa(wa[g]), .ra(ra[g]), .mw(mw[g]), .mr(mr[g]),
         .ovf(ovf[g]), .udf(udf[g])
      );
   end

   // External synchronous RAM: registered read data held between reads.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (mw[m]) mem[m][wa[m]] <= wdata[m];
         if (mr[m]) rdata[m] <= mem[m][ra[m]];
      end
   end

   task automatic drive(input logic w, input logic r, input logic f, input logic c);
      we      = {w, w};
      re      = {r, r};
      flush   = {f, f};
      clr_err = {c, c};
      wdata[0] = 8'($urandom);
      wdata[1] = 8'($urandom);
   endtask

   // One clock: compare every output with the model, advance the model,
   // then move to the next falling edge. Called just after a falling edge.
   task automatic cycle();
      int         cnt;
      logic       full_e, empty_e, fw_e, fr_e, mr_e, dchk;
      logic [7:0] d_e;
      #1;
      for (int m = 0; m < 2; m++) begin
         cnt     = wr_n[m] - rd_n[m];
         full_e  = (cnt == DP);
         empty_e = (m == 0) ? (cnt == 0) : (fe_n[m] == rd_n[m]);
         fw_e    = rst_n & we[m] & ~full_e & ~flush[m];
         fr_e    = rst_n & re[m] & ~empty_e & ~flush[m];
         // FWFT fetches the oldest unfetched word once the output slot frees.
         mr_e    = (m == 0) ? fr_e :
                   (rst_n & ~flush[m] & (wr_n[m] > fe_n[m]) & ((fe_n[m] == rd_n[m]) | fr_e));
         dchk    = (m == 0) ? pend_v[m] : ~empty_e;
         d_e     = (m == 0) ? pend_d[m] : dbuf[m][rd_n[m] % 4096];

         tests_run++; if (mw[m] !== fw_e) begin failed++; $display("FAIL mw m=%0d t=%0d got %b exp %b", m, now, mw[m], fw_e); end
         tests_run++; if (mr[m] !== mr_e) begin failed++; $display("FAIL mr m=%0d t=%0d got %b exp %b", m, now, mr[m], mr_e); end
         if (rst_n) begin
            tests_run++; if (count[m] !== CW'(cnt)) begin failed++; $display("FAIL count m=%0d t=%0d got %0d exp %0d", m, now, count[m], cnt); end
            tests_run++; if (empty[m] !== empty_e) begin failed++; $display("FAIL empty m=%0d t=%0d got %b exp %b", m, now, empty[m], empty_e); end
            tests_run++; if (full[m] !== full_e) begin failed++; $display("FAIL full m=%0d t=%0d got %b exp %b", m, now, full[m], full_e); end
            tests_run++; if (afull[m] !== (cnt >= int'(af_th))) begin failed++; $display("FAIL afull m=%0d t=%0d got %b cnt %0d th %0d", m, now, afull[m], cnt, af_th); end
            tests_run++; if (aempty[m] !== (cnt <= int'(ae_th))) begin failed++; $display("FAIL aempty m=%0d t=%0d got %b cnt %0d th %0d", m, now, aempty[m], cnt, ae_th); end
            tests_run++; if (wa[m] !== AW'(wr_n[m] % DP)) begin failed++; $display("FAIL wa m=%0d t=%0d got %0d exp %0d", m, now, wa[m], wr_n[m] % DP); end
            tests_run++; if (ra[m] !== AW'(((m == 0) ? rd_n[m] : fe_n[m]) % DP)) begin failed++; $display("FAIL ra m=%0d t=%0d got %0d", m, now, ra[m]); end
            tests_run++; if (ovf[m] !== m_ovf[m]) begin failed++; $display("FAIL ovf m=%0d t=%0d got %b exp %b", m, now, ovf[m], m_ovf[m]); end
            tests_run++; if (udf[m] !== m_udf[m]) begin failed++; $display("FAIL udf m=%0d t=%0d got %b exp %b", m, now, udf[m], m_udf[m]); end
            if (dchk) begin
               tests_run++; if (rdata[m] !== d_e) begin failed++; $display("FAIL rdata m=%0d t=%0d got %h exp %h", m, now, rdata[m], d_e); end
            end
         end

         if (!rst_n) begin
            wr_n[m] = 0; rd_n[m] = 0; fe_n[m] = 0;
            m_ovf[m] = 1'b0; m_udf[m] = 1'b0; pend_v[m] = 1'b0;
         end else begin
            m_ovf[m]  = (we[m] & full_e) | (m_ovf[m] & ~clr_err[m]);
            m_udf[m]  = (re[m] & empty_e) | (m_udf[m] & ~clr_err[m]);
            pend_v[m] = 1'b0;
            if (flush[m]) begin
               wr_n[m] = 0; rd_n[m] = 0; fe_n[m] = 0;
            end else begin
               if (fr_e) begin
                  if (m == 0) begin pend_v[m] = 1'b1; pend_d[m] = dbuf[m][rd_n[m] % 4096]; end
                  rd_n[m]++;
               end
               if (mr_e && m == 1) fe_n[m]++;
               if (fw_e) begin dbuf[m][wr_n[m] % 4096] = wdata[m]; wr_n[m]++; end
            end
         end
      end
      @(posedge clk);
      now++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      ae_th = '0;
      rst_n = 1'b0; drive(1, 1, 0, 0); cycle(); cycle();
      rst_n = 1'b1; drive(0, 0, 0, 0); #1;
      for (int m = 0; m < 2; m++) begin
         tests_run++; if (empty[m] !== 1'b1) begin failed++; $display("FAIL reset_empty m=%0d got %b exp 1", m, empty[m]); end
         tests_run++; if (full[m] !== 1'b0) begin failed++; $display("FAIL reset_full m=%0d got %b exp 0", m, full[m]); end
         tests_run++; if (aempty[m] !== 1'b1) begin failed++; $display("FAIL reset_aempty m=%0d got %b exp 1", m, aempty[m]); end
         tests_run++; if (count[m] !== '0) begin failed++; $display("FAIL reset_count m=%0d got %0d exp 0", m, count[m]); end
         tests_run++; if ({ovf[m], udf[m]} !== 2'b00) begin failed++; $display("FAIL reset_err m=%0d got %b%b exp 00", m, ovf[m], udf[m]); end
      end
      cycle();
      ae_th = CW'(1);
   endtask

   task automatic test_fill_drain();
      drive(0, 0, 1, 1); cycle();
      for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0); cycle(); end
      #1;
      tests_run++; if (count[0] !== CW'(5) || full[0] !== 1'b1) begin failed++; $display("FAIL fill_full count %0d full %b exp 5/1", count[0], full[0]); end
      drive(1, 0, 0, 0); #1;
      tests_run++; if (mw[0] !== 1'b0) begin failed++; $display("FAIL write_at_full mw %b exp 0", mw[0]); end
      cycle(); #1;
      tests_run++; if (ovf[0] !== 1'b1) begin failed++; $display("FAIL ovf_set got %b exp 1", ovf[0]); end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0); #1;
         tests_run++; if (ra[0] !== AW'(i) || mr[0] !== 1'b1) begin failed++; $display("FAIL drain_ra i=%0d ra %0d mr %b exp %0d/1", i, ra[0], mr[0], i); end
         cycle();
      end
      #1;
      tests_run++; if (empty[0] !== 1'b1 || count[0] !== '0) begin failed++; $display("FAIL drain_empty empty %b count %0d exp 1/0", empty[0], count[0]); end
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 1); cycle();
      for (int i = 0; i < 13; i++) begin
         drive(i < 12, i > 0, 0, 0); #1;
         if (i < 12) begin
            tests_run++; if (wa[0] !== AW'(i % 5) || mw[0] !== 1'b1) begin failed++; $display("FAIL wrap_wa i=%0d wa %0d mw %b exp %0d/1", i, wa[0], mw[0], i % 5); end
         end
         if (i > 0) begin
            tests_run++; if (ra[0] !== AW'((i - 1) % 5) || mr[0] !== 1'b1) begin failed++; $display("FAIL wrap_ra i=%0d ra %0d mr %b exp %0d/1", i, ra[0], mr[0], (i - 1) % 5); end
         end
         if (i > 0 && i < 12) begin
            tests_run++; if (count[0] !== CW'(1)) begin failed++; $display("FAIL wrap_count i=%0d got %0d exp 1", i, count[0]); end
         end
         cycle();
      end
   endtask

   task automatic test_fwft_latency();
      drive(0, 0, 1, 1); cycle();
      drive(1, 0, 0, 0); #1;
      tests_run++; if (mw[1] !== 1'b1 || mr[1] !== 1'b0) begin failed++; $display("FAIL fwft_c0 mw %b mr %b exp 1/0", mw[1], mr[1]); end
      cycle();
      drive(0, 0, 0, 0); #1;
      tests_run++; if (mr[1] !== 1'b1 || empty[1] !== 1'b1) begin failed++; $display("FAIL fwft_c1 mr %b empty %b exp 1/1", mr[1], empty[1]); end
      cycle(); #1;
      tests_run++; if (empty[1] !== 1'b0 || count[1] !== CW'(1)) begin failed++; $display("FAIL fwft_c2 empty %b count %0d exp 0/1", empty[1], count[1]); end
      cycle();
      drive(0, 1, 0, 0); cycle();
      drive(0, 0, 0, 0); #1;
      tests_run++; if (empty[1] !== 1'b1 || count[1] !== '0) begin failed++; $display("FAIL fwft_c4 empty %b count %0d exp 1/0", empty[1], count[1]); end
      cycle();
   endtask

   task automatic test_thresholds();
      af_th = CW'(4); ae_th = CW'(1);
      drive(0, 0, 1, 1); cycle();
      for (int k = 0; k <= 5; k++) begin
         drive(k < 5, 0, 0, 0); #1;
         tests_run++; if (aempty[0] !== (k <= 1) || afull[0] !== (k >= 4)) begin failed++; $display("FAIL thresh k=%0d aempty %b afull %b", k, aempty[0], afull[0]); end
         cycle();
      end
      af_th = CW'(6); #1;
      tests_run++; if (afull[0] !== 1'b0 || afull[1] !== 1'b0) begin failed++; $display("FAIL thresh_above_depth afull %b%b exp 00", afull[1], afull[0]); end
      af_th = CW'(4);
   endtask

   task automatic test_flush();
      drive(0, 0, 1, 1); cycle();
      drive(0, 1, 0, 0); cycle();
      for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0); cycle(); end
      cycle();
      drive(1, 1, 1, 0); #1;
      tests_run++; if (mw !== 2'b00 || mr !== 2'b00) begin failed++; $display("FAIL flush_mem mw %b mr %b exp 00/00", mw, mr); end
      cycle(); drive(0, 0, 0, 0); #1;
      for (int m = 0; m < 2; m++) begin
         tests_run++; if (count[m] !== '0 || empty[m] !== 1'b1 || udf[m] !== 1'b1) begin failed++; $display("FAIL flush_state m=%0d count %0d empty %b udf %b exp 0/1/1", m, count[m], empty[m], udf[m]); end
      end
      cycle();
   endtask

   task automatic test_errors();
      drive(0, 0, 1, 1); cycle();
      drive(0, 1, 0, 0); cycle(); #1;
      tests_run++; if (udf !== 2'b11) begin failed++; $display("FAIL udf_set got %b exp 11", udf); end
      drive(0, 1, 0, 1); cycle(); #1;
      tests_run++; if (udf !== 2'b11) begin failed++; $display("FAIL udf_set_wins got %b exp 11", udf); end
      drive(0, 0, 0, 1); cycle(); #1;
      tests_run++; if (udf !== 2'b00) begin failed++; $display("FAIL udf_clear got %b exp 00", udf); end
   endtask

   task automatic test_mid_reset();
      drive(1, 0, 0, 0); cycle(); cycle();
      rst_n = 1'b0; drive(1, 0, 0, 0); #1;
      tests_run++; if (mw !== 2'b00) begin failed++; $display("FAIL reset_no_write mw %b exp 00", mw); end
      cycle();
      rst_n = 1'b1; drive(0, 0, 0, 0); #1;
      tests_run++; if (count[0] !== '0 || count[1] !== '0 || empty !== 2'b11) begin failed++; $display("FAIL reset_discard count %0d/%0d empty %b", count[0], count[1], empty); end
      cycle();
   endtask

   task automatic test_random();
      int wb, rb;
      for (int n = 0; n < 1500; n++) begin
         if (n % 150 == 0) begin
            wb = $urandom_range(20, 90);
            rb = $urandom_range(20, 90);
         end
         if (n % 100 == 0) begin
            af_th = CW'($urandom_range(0, 7));
            ae_th = CW'($urandom_range(0, 7));
         end
         rst_n = ($urandom_range(0, 399) != 0);
         for (int m = 0; m < 2; m++) begin
            we[m]      = ($urandom_range(0, 99) < wb);
            re[m]      = ($urandom_range(0, 99) < rb);
            flush[m]   = ($urandom_range(0, 49) == 0);
            clr_err[m] = ($urandom_range(0, 15) == 0);
            wdata[m]   = 8'($urandom);
         end
         cycle();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      af_th = CW'(4);
      ae_th = CW'(1);
      drive(0, 0, 0, 0);
      for (int m = 0; m < 2; m++) begin
         wr_n[m] = 0; rd_n[m] = 0; fe_n[m] = 0;
         m_ovf[m] = 1'b0; m_udf[m] = 1'b0; pend_v[m] = 1'b0; pend_d[m] = '0;
      end
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_wrap();
      test_fwft_latency();
      test_thresholds();
      test_flush();
      test_errors();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
